// File: rtl/led_reg_arbiter_if.sv
// Requester-side handshake bundle for led_reg_arbiter.
// Requester i drives req_valid[i] and req_data[i*WIDTH +: WIDTH].
// The arbiter answers with a one-hot req_ready.
interface led_reg_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 30
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;

  // Requesters drive valid/data and observe ready
  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  // The arbiter observes valid/data and drives ready
  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/led_reg_arbiter.sv
// Round-robin arbiter in front of a shared LED pipeline register.
// One word is accepted at a time and driven onto the register's d input.
// The register output is compared against d in the first HOLD cycle.
// A fixed HOLD window then keeps the LEDs stable before the next update.
module led_reg_arbiter #(
  parameter int               NUM_REQ     = 4,
  parameter int               WIDTH       = 30,
  parameter int               HOLD_CYCLES = 16,
  parameter logic [WIDTH-1:0] RESET_WORD  = '0
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  led_reg_arbiter_if.slave                                req,
  output logic [WIDTH-1:0]                                reg_d,
  input  logic [WIDTH-1:0]                                reg_q,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
  output logic                                            update_pulse,
  output logic                                            busy,
  output logic                                            err
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IDX_W = ID_W + 1;
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      winner;
  logic [ID_W-1:0]      ptr_after;
  logic                 found;
  logic [IDX_W-1:0]     idx;
  logic [NUM_REQ-1:0]   ready;
  logic                 handshake;
  logic [CNT_W-1:0]     count;

  // Scan requesters starting at the pointer, wrapping at NUM_REQ-1, first valid wins
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + IDX_W'(k);
      if (idx >= IDX_W'(NUM_REQ)) begin
        idx = idx - IDX_W'(NUM_REQ);
      end
      if (!found && req.req_valid[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[ID_W-1:0];
      end
    end
  end

  // One-hot ready only in IDLE and never while reset is asserted
  always_comb begin
    ready = '0;
    if (rst_n && (state == IDLE) && found) begin
      ready[winner] = 1'b1;
    end
  end

  assign req.req_ready = ready;
  assign handshake     = |(req.req_valid & ready);
  assign ptr_after     = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
  assign busy          = (state != IDLE);

  // Next-state logic: IDLE waits for a handshake, LOAD lasts one cycle, HOLD runs until the counter drains
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (handshake) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        state_next = HOLD;
      end
      HOLD: begin
        if (count == '0) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, datapath and write-back check; the pulse doubles as the first-HOLD-cycle marker
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      reg_d        <= RESET_WORD;
      grant_id     <= '0;
      ptr          <= '0;
      count        <= '0;
      update_pulse <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_next;
      update_pulse <= (state == LOAD);
      if (handshake) begin
        reg_d    <= req.req_data[winner*WIDTH +: WIDTH];
        grant_id <= winner;
        ptr      <= ptr_after;
      end
      if (state == LOAD) begin
        count <= CNT_W'(HOLD_CYCLES - 1);
      end else if ((state == HOLD) && (count != '0)) begin
        count <= count - CNT_W'(1);
      end
      if (update_pulse && (reg_q != reg_d)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_reg_arbiter.sv
// Self-checking bench for led_reg_arbiter.
// A cycle-count model of the arbiter predicts every output each cycle.
// Directed sections pin that model with hand-computed values; a random phase follows.
module tb_led_reg_arbiter;

  localparam int             N  = 4;
  localparam int             W  = 30;
  localparam int             HC = 16;
  localparam logic [W-1:0]   RW = '0;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  reg_d;
  logic [W-1:0]  reg_q = '0;
  logic [1:0]    grant_id;
  logic          update_pulse;
  logic          busy;
  logic          err;
  logic          corrupt = 1'b0;
  bit            checking = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: cycles since the last accept (-1 when idle)
  int            m_since = -1;
  int            m_ptr   = 0;
  int            m_gid   = 0;
  logic [W-1:0]  m_d     = '0;
  logic [W-1:0]  m_q     = '0;
  bit            m_err   = 1'b0;

  // Accept log for directed sections
  int acc_id [8];
  int acc_t  [8];
  logic [W-1:0] acc_d [8];
  int n_acc;
  int busy_cnt;
  logic [W-1:0] words [N];

  led_reg_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  led_reg_arbiter #(
    .NUM_REQ(N),
    .WIDTH(W),
    .HOLD_CYCLES(HC),
    .RESET_WORD(RW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(bus),
    .reg_d(reg_d),
    .reg_q(reg_q),
    .grant_id(grant_id),
    .update_pulse(update_pulse),
    .busy(busy),
    .err(err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // The shared register; corrupt forces a bad capture to provoke the write-back check
  always @(posedge clk) reg_q <= corrupt ? '0 : reg_d;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: an accept opens a window of HC+1 busy cycles, the pulse falls in window cycle 1
  always @(posedge clk) begin : model
    int w;
    if (!rst_n) begin
      m_q     = corrupt ? '0 : m_d;
      m_since = -1;
      m_ptr   = 0;
      m_gid   = 0;
      m_d     = RW;
      m_err   = 1'b0;
    end else begin
      if (m_since == 1 && m_q != m_d) m_err = 1'b1;
      m_q = corrupt ? '0 : m_d;
      if (m_since < 0) begin
        w = pick(bus.req_valid, m_ptr);
        if (w >= 0) begin
          m_d     = bus.req_data[w*W +: W];
          m_gid   = w;
          m_ptr   = (w + 1) % N;
          m_since = 0;
        end
      end else begin
        m_since++;
        if (m_since > HC) m_since = -1;
      end
    end
  end

  // Compare every DUT output against the model on each falling edge
  always @(negedge clk) begin : compare
    logic [N-1:0] er;
    int w;
    if (checking) begin
      er = '0;
      if (rst_n && m_since < 0) begin
        w = pick(bus.req_valid, m_ptr);
        if (w >= 0) er[w] = 1'b1;
      end
      check_output("req_ready", 32'(bus.req_ready), 32'(er));
      check_output("reg_d", 32'(reg_d), 32'(m_d));
      check_output("grant_id", 32'(grant_id), 32'(m_gid));
      check_output("update_pulse", 32'(update_pulse), 32'(m_since == 1));
      check_output("busy", 32'(busy), 32'(m_since >= 0));
      check_output("err", 32'(err), 32'(m_err));
    end
  end

  // Log accepts (busy rising) until n are seen or the cycle budget runs out
  task automatic collect(input int n, input int max_cycles);
    logic prev;
    prev  = busy;
    n_acc = 0;
    for (int c = 0; c < max_cycles && n_acc < n; c++) begin
      @(negedge clk);
      if (busy && !prev) begin
        acc_id[n_acc] = int'(grant_id);
        acc_t[n_acc]  = c;
        acc_d[n_acc]  = reg_d;
        n_acc++;
      end
      prev = busy;
    end
    check_output("accept_count", 32'(n_acc), 32'(n));
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;

    // Reset hold with all valids high
    for (int i = 0; i < N; i++) words[i] = W'(30'h1000 * (i + 1) + 30'h0AB);
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = words[i];
    bus.req_valid = '1;
    rst_n = 1'b0;
    step();
    checking = 1'b1;
    step();
    @(negedge clk);
    check_output("rst_ready", 32'(bus.req_ready), 32'h0);
    check_output("rst_reg_d", 32'(reg_d), 32'(RW));
    check_output("rst_busy", 32'(busy), 32'h0);
    check_output("rst_err", 32'(err), 32'h0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check_output("post_rst_ready", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = '0;
    repeat (HC + 3) step();

    // Single write from requester 2
    bus.req_data[2*W +: W] = 30'h2AAAAAAA;
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = '0;
    busy_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check_output("single_reg_d", 32'(reg_d), 32'h2AAAAAAA);
        check_output("single_grant", 32'(grant_id), 32'd2);
        check_output("single_pulse_early", 32'(update_pulse), 32'h0);
      end
      if (c == 1) check_output("single_pulse", 32'(update_pulse), 32'h1);
      if (busy) busy_cnt++;
      step();
    end
    check_output("single_busy_len", 32'(busy_cnt), 32'd17);

    // Round-robin fairness from a fresh pointer
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) words[i] = W'(30'h3000000 + 30'h111 * (i + 1));
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = words[i];
    bus.req_valid = '1;
    collect(5, 120);
    step();
    bus.req_valid = '0;
    for (int i = 0; i < 5 && i < n_acc; i++) begin
      check_output("rr_grant", 32'(acc_id[i]), 32'(i % N));
      check_output("rr_word", 32'(acc_d[i]), 32'(words[i % N]));
      if (i > 0) check_output("rr_spacing", 32'(acc_t[i] - acc_t[i-1]), 32'd18);
    end
    repeat (HC + 3) step();

    // Wrap: grant 3 first, then 0 and 3 together must go 0 then 3
    bus.req_valid = 4'b1000;
    collect(1, 40);
    if (n_acc >= 1) check_output("wrap_first", 32'(acc_id[0]), 32'd3);
    step();
    bus.req_valid = 4'b1001;
    collect(2, 60);
    step();
    bus.req_valid = '0;
    if (n_acc >= 2) begin
      check_output("wrap_second", 32'(acc_id[0]), 32'd0);
      check_output("wrap_third", 32'(acc_id[1]), 32'd3);
    end
    repeat (HC + 3) step();

    // Write-back check: the register captures zero instead of 0x155
    corrupt = 1'b1;
    bus.req_data[1*W +: W] = 30'h155;
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = '0;
    step();
    corrupt = 1'b0;
    repeat (HC + 3) step();
    @(negedge clk);
    check_output("wb_err_set", 32'(err), 32'h1);
    bus.req_data[0*W +: W] = 30'h0ABCDEF;
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = '0;
    repeat (HC + 3) step();
    @(negedge clk);
    check_output("wb_err_sticky", 32'(err), 32'h1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check_output("wb_err_cleared", 32'(err), 32'h0);

    // Reset in HOLD cycle 5 discards the word
    bus.req_data[2*W +: W] = 30'h1234567;
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = '0;
    repeat (5) step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    check_output("midhold_busy", 32'(busy), 32'h0);
    check_output("midhold_reg_d", 32'(reg_d), 32'(RW));
    check_output("midhold_pulse", 32'(update_pulse), 32'h0);
    check_output("midhold_grant", 32'(grant_id), 32'h0);
    step();
    rst_n = 1'b1;
    bus.req_valid = '1;
    @(negedge clk);
    check_output("midhold_ptr", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = '0;
    repeat (HC + 3) step();

    // Randomized traffic with occasional bad captures and resets
    for (int c = 0; c < 3000; c++) begin
      bus.req_valid = N'($urandom);
      for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = W'($urandom);
      corrupt = ($urandom_range(0, 19) == 0);
      rst_n   = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1'b1;
    corrupt = 1'b0;
    step();
    checking = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_reg_arbiter.md
Name: led_reg_arbiter

Overview:
- Round-robin arbiter that shares one 30-bit LED pipeline register between NUM_REQ requesters.
- The register loads its input every clock, so this block owns and holds the register's d input stable.
- It accepts one word at a time over a valid/ready handshake, drives it onto the register, and checks that the register output matches one cycle later.
- It then enforces a minimum hold time before the next update, so the LED output stays stable.

Parameters:
- NUM_REQ, 4: number of requesters; must be >= 1.
- WIDTH, 30: word width; matches the shared register.
- HOLD_CYCLES, 16: cycles the HOLD state lasts after each update; must be >= 1.
- RESET_WORD, 30'h0: value driven on reg_d after reset.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- req_valid  input  NUM_REQ  per-requester word-valid.
- req_data  input  NUM_REQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  output  NUM_REQ  one-hot accept; combinational.
- reg_d  output  WIDTH  drives d of the shared register; registered.
- reg_q  input  WIDTH  q of the shared register, used for write-back check.
- grant_id  output  $clog2(NUM_REQ) (min 1)  index of the last accepted requester; registered.
- update_pulse  output  1  one-cycle strobe when a new word is visible on reg_q.
- busy  output  1  high whenever state != IDLE.
- err  output  1  sticky write-back mismatch flag.

Behaviour:
- Reset (rst_n=0 at posedge):
  - State goes to IDLE.
  - reg_d=RESET_WORD, grant_id=0, update_pulse=0, err=0.
  - Round-robin pointer=0; hold counter=0.
  - req_ready=0 while rst_n=0.
- Reset mid-operation: the same values apply on the next edge. A word in LOAD or HOLD is discarded, with no update_pulse and no err update.
- States are IDLE, LOAD and HOLD.
- IDLE:
  - Winner w = first i with req_valid[i]=1, scanning from the pointer upward, wrapping NUM_REQ-1 to 0.
  - req_ready[w]=1; all other ready bits are 0; all ready bits are 0 if no valid is high.
  - Handshake = req_valid[w] & req_ready[w] at a posedge. On it:
    - reg_d <= req_data[w], grant_id <= w.
    - pointer <= (w+1) mod NUM_REQ.
    - state <= LOAD.
  - No valid: stay in IDLE; reg_d holds.
- LOAD (1 cycle): the register captures reg_d at the end of this cycle; state <= HOLD; counter <= HOLD_CYCLES-1.
- HOLD:
  - First HOLD cycle: update_pulse=1.
  - First HOLD cycle: if reg_q != reg_d then err <= 1; err is sticky until reset.
  - Counter decrements each cycle; at 0, state <= IDLE. HOLD lasts exactly HOLD_CYCLES cycles.
- req_ready=0 in LOAD and HOLD.
- Back-to-back accepts are spaced HOLD_CYCLES+2 cycles apart.
- reg_d changes only on a handshake or reset, so it is stable for the whole LOAD and HOLD period.
- Requesters may drop valid before acceptance; nothing is latched in that case. Data is sampled only at the handshake edge.
- Simultaneous valids: round-robin order only; no requester is starved. Each valid requester is granted within NUM_REQ accepts.
- NUM_REQ=1: pointer is always 0; grant_id width is 1 with value 0.
- Pointer updates only on a handshake.

Test Plan:
- Reset hold:
  - Stimulus: rst_n=0 for 3 cycles with all valids high.
  - Response: req_ready=0, reg_d=RESET_WORD, busy=0, err=0.
  - After release, req_ready=4'b0001 in the first cycle.
- Single write:
  - Stimulus: req_valid=4'b0100, data[2]=30'h2AAAAAAA.
  - Response: reg_d=30'h2AAAAAAA one cycle after the handshake, grant_id=2, update_pulse two cycles after the handshake.
  - busy is high for exactly HOLD_CYCLES+1=17 cycles.
- Round-robin fairness:
  - Stimulus: all 4 valids held high, distinct data words.
  - Response: grants in order 0,1,2,3,0; accepts spaced exactly 18 cycles apart.
  - Each reg_d matches the granted word.
- Wrap and pointer:
  - Stimulus: grant requester 3 first, then raise valids 0 and 3 together.
  - Response: next grant = 0, then 3.
- Write-back check:
  - Stimulus: force reg_q=30'h0 while reg_d=30'h155 in the first HOLD cycle.
  - Response: err=1, and it remains 1 through later correct writes until rst_n=0.
- Reset mid-HOLD:
  - Stimulus: assert rst_n=0 at HOLD cycle 5.
  - Response: next edge gives state IDLE, reg_d=RESET_WORD, pointer=0, no update_pulse.
